// File: rtl/prog_loader_pkg.sv
// Shared types for the instruction-memory program loader.
package prog_loader_pkg;
    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {IDLE, HDR, DATA, WR, CHK, DONE, ERR} state_t;
endpackage

// File: rtl/prog_loader_byte_packer.sv
// Packs a byte stream MSB-first into words; word is valid combinationally with word_done.
module byte_packer
    import prog_loader_pkg::*;
#(
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              xfer,
    input  logic [BYTE_W-1:0] byte_in,
    output logic [WORD_W-1:0] word,
    output logic              word_done
);
    localparam int BYTES = WORD_W / BYTE_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    logic [CNT_W-1:0]  cnt;
    logic [WORD_W-1:0] shreg;

    assign word_done = xfer && (cnt == CNT_W'(BYTES - 1));

    // The final byte is merged in the same cycle so the FSM can act on the full word.
    generate
        if (BYTES > 1) begin : g_multi
            assign word = {shreg[WORD_W-BYTE_W-1:0], byte_in};
        end else begin : g_single
            assign word = byte_in;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt   <= '0;
            shreg <= '0;
        end else if (xfer) begin
            shreg <= word;
            cnt   <= word_done ? '0 : cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Streams a header-prefixed program into instruction memory and releases cpu_run when complete.
// Optional trailing XOR checksum word: define PROG_LOADER_CHECKSUM_EN.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int INSTRUCTION_LEN = 16,
    parameter int ADDR_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       in_valid,
    input  logic [BYTE_W-1:0]          in_data,
    output logic                       in_ready,
    output logic                       im_wr_en,
    output logic [ADDR_W-1:0]          im_addr,
    output logic [INSTRUCTION_LEN-1:0] im_wr_data,
    output logic                       busy,
    output logic                       cpu_run,
    output logic                       error,
    output logic [ADDR_W:0]            loaded_count
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CW    = ADDR_W + 1;
`ifdef PROG_LOADER_CHECKSUM_EN
    localparam state_t FIN = CHK;
`else
    localparam state_t FIN = DONE;
`endif

    state_t                     state, state_nxt;
    logic                       xfer, word_done, clr, start_ok, hdr_big, last_wr;
    logic [INSTRUCTION_LEN-1:0] word;
    logic [CW-1:0]              n, wcnt;
    logic                       in_ready_d, im_wr_en_d, busy_d, cpu_run_d, error_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [INSTRUCTION_LEN-1:0] csum;
`endif

    assign start_ok     = start && (state == IDLE || state == DONE || state == ERR);
    assign clr          = rst || start_ok;
    assign xfer         = in_valid && in_ready;
    assign hdr_big      = 64'(word) > 64'(DEPTH);
    assign last_wr      = (wcnt + CW'(1)) == n;
    assign im_addr      = wcnt[ADDR_W-1:0];
    assign loaded_count = wcnt;

    byte_packer #(.WORD_W(INSTRUCTION_LEN)) u_packer (
        .clk       (clk),
        .clr       (clr),
        .xfer      (xfer),
        .byte_in   (in_data),
        .word      (word),
        .word_done (word_done)
    );

    // State and the state-decoded outputs share one register so every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            im_wr_en <= 1'b0;
            busy     <= 1'b0;
            cpu_run  <= 1'b0;
            error    <= 1'b0;
        end else begin
            state    <= state_nxt;
            in_ready <= in_ready_d;
            im_wr_en <= im_wr_en_d;
            busy     <= busy_d;
            cpu_run  <= cpu_run_d;
            error    <= error_d;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (start) state_nxt = HDR;
            HDR: begin
                if (word_done) begin
                    if (word == '0)   state_nxt = FIN;
                    else if (hdr_big) state_nxt = ERR;
                    else              state_nxt = DATA;
                end
            end
            DATA:       if (word_done) state_nxt = WR;
            WR:         state_nxt = last_wr ? FIN : DATA;
`ifdef PROG_LOADER_CHECKSUM_EN
            CHK:        if (word_done) state_nxt = (word == csum) ? DONE : ERR;
`endif
            DONE, ERR:  if (start) state_nxt = HDR;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready_d = (state_nxt == HDR) || (state_nxt == DATA) || (state_nxt == CHK);
        im_wr_en_d = (state_nxt == WR);
        busy_d     = in_ready_d || im_wr_en_d;
        cpu_run_d  = (state_nxt == DONE);
        error_d    = (state_nxt == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n          <= '0;
            wcnt       <= '0;
            im_wr_data <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            csum       <= '0;
`endif
        end else begin
            if (start_ok) begin
                n    <= '0;
                wcnt <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum <= '0;
`endif
            end
            if (state == HDR && word_done) n <= CW'(word);
            if (state == DATA && word_done) begin
                im_wr_data <= word;
`ifdef PROG_LOADER_CHECKSUM_EN
                csum       <= csum ^ word;
`endif
            end
            if (state == WR) wcnt <= wcnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: expected writes are queued by stimulus, popped by a write monitor.
module tb_prog_loader;
    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_ready, im_wr_en, busy, cpu_run, error;
    logic [7:0]  im_addr;
    logic [15:0] im_wr_data;
    logic [8:0]  loaded_count;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_xfer_cyc = -1;
    wr_t sb[$];

    prog_loader #(.INSTRUCTION_LEN(16), .ADDR_W(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .im_wr_en     (im_wr_en),
        .im_addr      (im_addr),
        .im_wr_data   (im_wr_data),
        .busy         (busy),
        .cpu_run      (cpu_run),
        .error        (error),
        .loaded_count (loaded_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (im_wr_en) begin
            wr_t e;
            chk("ready_in_wr", {31'd0, in_ready}, 32'd0);
            chk("wr_latency", cyc, last_xfer_cyc);
            if (sb.size() == 0) begin
                chk("unexpected_wr", {im_addr, im_wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", {24'd0, im_addr}, {24'd0, e.addr});
                chk("wr_data", {16'd0, im_wr_data}, {16'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit done = 0;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50 && !done; k++) begin
            if (in_ready) begin
                tick();
                last_xfer_cyc = cyc;
                done = 1;
            end else begin
                tick();
            end
        end
        in_valid = 1'b0;
        if (!done) chk("byte_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [15:0] w, input int maxgap);
        send_byte(w[15:8], $urandom_range(0, maxgap));
        send_byte(w[7:0], $urandom_range(0, maxgap));
    endtask

    task automatic send_data(input logic [7:0] a, input logic [15:0] w, input int maxgap);
        sb.push_back('{addr: a, data: w});
        send_word(w, maxgap);
    endtask

    task automatic send_csum(input logic [15:0] w);
`ifdef PROG_LOADER_CHECKSUM_EN
        send_word(w, 0);
`else
        if (w === 16'hxxxx) $display("unused checksum word");
`endif
    endtask

    task automatic wait_end(input string name);
        bit done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            if (cpu_run || error) done = 1;
            else tick();
        end
        if (!done) chk({name, "_timeout"}, 32'd0, 32'd1);
        repeat (2) tick();
    endtask

    task automatic chk_end(input string name, input logic run, input logic err, input logic [8:0] lc);
        chk({name, "_cpu_run"}, {31'd0, cpu_run}, {31'd0, run});
        chk({name, "_error"}, {31'd0, error}, {31'd0, err});
        chk({name, "_loaded"}, {23'd0, loaded_count}, {23'd0, lc});
        chk({name, "_busy_ready"}, {30'd0, busy, in_ready}, 32'd0);
        chk({name, "_sb_empty"}, sb.size(), 32'd0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_flags"}, {27'd0, in_ready, im_wr_en, busy, cpu_run, error}, 32'd0);
        chk({name, "_addr"}, {24'd0, im_addr}, 32'd0);
        chk({name, "_wdata"}, {16'd0, im_wr_data}, 32'd0);
        chk({name, "_loaded"}, {23'd0, loaded_count}, 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        chk_idle("reset");
        rst = 1'b0;
        tick();
        chk_idle("idle");

        // Basic load with back-to-back bytes.
        start_pulse();
        chk("hdr_busy", {30'd0, busy, in_ready}, 32'd3);
        send_word(16'h0002, 0);
        send_data(8'd0, 16'h1234, 0);
        send_data(8'd1, 16'hABCD, 0);
        send_csum(16'hB9F9);
        wait_end("basic");
        chk_end("basic", 1'b1, 1'b0, 9'd2);

        // Random valid gaps; start held mid-load must be ignored.
        start_pulse();
        send_word(16'h0004, 3);
        start = 1'b1;
        send_data(8'd0, 16'h0001, 3);
        start = 1'b0;
        send_data(8'd1, 16'hFFFF, 3);
        send_data(8'd2, 16'h8000, 3);
        send_data(8'd3, 16'h5A5A, 3);
        send_csum(16'h25A4);
        wait_end("bp");
        chk_end("bp", 1'b1, 1'b0, 9'd4);

        // Header one past memory depth.
        start_pulse();
        send_word(16'h0101, 0);
        wait_end("oversize");
        chk_end("oversize", 1'b0, 1'b1, 9'd0);

        // Exactly DEPTH is not oversize; abort it with reset after one word.
        start_pulse();
        send_word(16'h0100, 0);
        chk("depth_ok_error", {31'd0, error}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;

        // Zero-length program.
        tick();
        start_pulse();
        send_word(16'h0000, 0);
        send_csum(16'h0000);
        wait_end("zero");
        chk_end("zero", 1'b1, 1'b0, 9'd0);

        // Reset after the first byte of word 1.
        start_pulse();
        send_word(16'h0003, 0);
        send_data(8'd0, 16'h1111, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        tick();
        chk_idle("midrst");
        rst = 1'b0;
        repeat (3) tick();
        chk_idle("midrst_hold");
        start_pulse();
        send_word(16'h0001, 1);
        send_data(8'd0, 16'h7777, 1);
        send_csum(16'h7777);
        wait_end("reload");
        chk_end("reload", 1'b1, 1'b0, 9'd1);

`ifdef PROG_LOADER_CHECKSUM_EN
        // Wrong checksum: data stays written, load ends in ERR.
        start_pulse();
        send_word(16'h0002, 0);
        send_data(8'd0, 16'h1234, 0);
        send_data(8'd1, 16'hABCD, 0);
        send_word(16'hB9F8, 0);
        wait_end("badsum");
        chk_end("badsum", 1'b0, 1'b1, 9'd2);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that fills the instruction memory before the multi-cycle processor runs: it is the writer side of the instruction store that the controller fetches from. It accepts a byte stream over a valid/ready handshake, packs bytes MSB-first into INSTRUCTION_LEN-bit words, and writes them to consecutive instruction-memory addresses from 0. It holds `cpu_run` low until the whole program is committed, so the processor starts only on a complete image.

## Interface
- `INSTRUCTION_LEN`, 16: instruction width. Must be a multiple of 8; BYTES = INSTRUCTION_LEN/8.
- `ADDR_W`, 8: instruction-memory address width. DEPTH = 2**ADDR_W.
- `clk  in  1`: clock. All logic samples on the rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: pulse that begins a load. Sampled only in IDLE, DONE and ERR.
- `in_valid  in  1`: a byte is offered on `in_data`.
- `in_data  in  8`: stream byte.
- `in_ready  out  1`: the loader can accept a byte. A transfer occurs when `in_valid & in_ready`.
- `im_wr_en  out  1`: one-cycle instruction-memory write strobe.
- `im_addr  out  ADDR_W`: write address.
- `im_wr_data  out  INSTRUCTION_LEN`: write data.
- `busy  out  1`: a load is in progress.
- `cpu_run  out  1`: the program is loaded and the processor may run.
- `error  out  1`: the load was aborted.
- `loaded_count  out  ADDR_W+1`: number of words written so far.

## Operation
- The stream format is a header word N (the instruction count), followed by N instruction words. Each word is BYTES bytes, most significant byte first.
- States and transitions:
  - IDLE: on `start`, go to HDR.
  - HDR: collect the header word.
    - N == 0: go to DONE (or CHK, see Configuration).
    - N > DEPTH: go to ERR.
    - Otherwise: go to DATA.
  - DATA: collect one word, then go to WR.
  - WR: write the word, increment the address. If the address reaches N, go to DONE or CHK; otherwise return to DATA.
  - DONE: idle with `cpu_run` high.
  - ERR: idle with `error` high.
  - From DONE or ERR, `start` returns to HDR. This clears `cpu_run`, `error`, `loaded_count` and the address.
- `in_ready` is 1 only in HDR, DATA and CHK; it is 0 in WR, IDLE, DONE and ERR.
- The byte counter is 0..BYTES-1. The word completes on the transfer where the counter equals BYTES-1; the counter then wraps to 0.
- `im_addr` equals the index of the word being written (0..N-1). `loaded_count` increments in the WR cycle.
- `busy` is 1 in HDR, DATA, WR and CHK.
- `start` asserted during a load is ignored.
- Reset values: state IDLE; all outputs 0, including `im_addr`, `im_wr_data` and `loaded_count`. Byte counter and checksum are also 0.
- Reset mid-load: the next cycle is IDLE with no write strobe, and any partial word is discarded. Words already written stay in memory, but `cpu_run` stays 0.

## Timing
- A byte is accepted in the same cycle that the handshake completes.
- `im_wr_en` pulses exactly one cycle after the final byte of a data word is accepted. `im_addr` and `im_wr_data` are valid during that cycle.
- Because of the WR bubble, maximum throughput is one word per BYTES+1 cycles.
- `cpu_run` rises one cycle after the last WR cycle (no checksum), or one cycle after the last checksum byte (with checksum).
- `error` rises one cycle after the offending header byte or checksum byte.
- All outputs are registered.

## Configuration
- `PROG_LOADER_CHECKSUM_EN` defined:
  - After the final WR, the FSM enters CHK and collects one more word.
  - This word is compared with the running XOR of all N data words (initial value 0).
  - Match: go to DONE. Mismatch: go to ERR. Data already written is not erased.
  - With N == 0, HDR goes to CHK and the expected value is 0.
- Undefined: the CHK state and checksum register are absent, and the last WR (or N == 0) goes directly to DONE.

## Structure
- Package `prog_loader_pkg` holds:
  - the state enum: IDLE, HDR, DATA, WR, CHK, DONE, ERR;
  - `BYTE_W = 8`.
- Sub-module `byte_packer`:
  - byte counter and shift register;
  - outputs `word` and a one-cycle `word_done` pulse;
  - clear input driven by the FSM on `start` and `rst`.
- The FSM, address counter and checksum live in `prog_loader`.

## Test plan
- Basic load:
  - Stimulus: `start`, then bytes 00 02 | 12 34 | AB CD.
  - Required: writes addr 0 = 0x1234 and addr 1 = 0xABCD, each one cycle after its low byte; then `cpu_run` = 1 and `loaded_count` = 2.
- Backpressure:
  - Stimulus: `in_valid` toggled randomly.
  - Required: `in_ready` is 0 in every WR cycle, no byte is lost or duplicated, and memory contents match the stream.
- Oversize header:
  - Stimulus: with ADDR_W = 8, header 01 01 (257).
  - Required: `error` = 1, no `im_wr_en` pulse, `cpu_run` = 0.
- Zero-length program:
  - Stimulus: header 00 00.
  - Required: `cpu_run` = 1 with no writes. With the macro defined, trailing checksum 00 00 is also required before `cpu_run`.
- Reset mid-load:
  - Stimulus: `rst` asserted after the first byte of word 1.
  - Required: IDLE next cycle, all outputs 0, no further writes. A new `start` reloads correctly from addr 0.
- Checksum (macro defined):
  - Stimulus: words 0x1234 and 0xABCD, then checksum B9 F9.
  - Required: DONE.
  - Stimulus: same words with checksum B9 F8.
  - Required: ERR, `error` = 1, `cpu_run` = 0.
